// File: rtl/seq_addsub_chunked.sv
// seq_addsub_chunked
// Multi-cycle adder/subtractor. The operands are processed CHUNK bits per
// clock, least-significant chunk first, through a single CHUNK-bit adder.
// Subtraction is a + ~b + 1. Signed overflow is reported on the final chunk.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; the previous result is held on sum/cout/ovf
//   RUN     | one chunk added per clock; busy=1
//   DONE    | result valid; done=1 for one cycle, then back to IDLE
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   start request, sampled only in IDLE
//   sub    in   0: a+b+cin, 1: a-b (cin ignored)
//   cin    in   carry-in for add mode
//   a, b   in   operands [WIDTH], captured on the accepting edge
//   sum    out  result [WIDTH]
//   cout   out  carry-out of the MSB (sub mode: 1 = no borrow)
//   ovf    out  two's-complement overflow
//   busy   out  high in RUN
//   done   out  one-cycle result-valid pulse
module seq_addsub_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("seq_addsub_chunked: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Operands shift right one chunk per RUN cycle, so the active chunk is
    // always the low CHUNK bits; on the last chunk its top bit is the
    // original operand MSB, which is what the overflow rule needs.
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;
    logic              carry_q;
    logic [CW-1:0]     idx_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [CHUNK:0]    chunk_sum;
    logic              last_chunk;

    always_comb begin
        chunk_sum  = {1'b0, op_a_q[CHUNK-1:0]}
                   + {1'b0, op_b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (idx_q == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    op_a_q  <= op_a_q >> CHUNK;
                    op_b_q  <= op_b_q >> CHUNK;
                    carry_q <= chunk_sum[CHUNK];
                    idx_q   <= idx_q + CW'(1);
                    for (int j = 0; j < NCHUNK; j++) begin
                        if (32'(idx_q) == 32'(j)) begin
                            sum_q[j*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                        end
                    end
                    if (last_chunk) begin
                        cout_q <= chunk_sum[CHUNK];
                        ovf_q  <= (op_a_q[CHUNK-1] == op_b_q[CHUNK-1])
                               && (chunk_sum[CHUNK-1] != op_a_q[CHUNK-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
